// File: rtl/dispense_controller.sv
// Dispense sequencer: latches a confirmed target volume, drives the water valve,
// converts flow-meter pulses into millilitres and stops on target, cancel or fault.
module dispense_controller #(
    parameter int AMOUNT_WIDTH   = 14,
    parameter int PULSES_PER_ML  = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AMOUNT_WIDTH-1:0] target_amount,
    input  logic                    cancel,
    input  logic                    flow_pulse,
    input  logic                    tank_empty,
    output logic                    valve_open,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [1:0]              fault_code,
    output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
    output logic [AMOUNT_WIDTH-1:0] remaining_amount
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]           TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]           TIMEOUT_ONE  = TW'(1);
    localparam logic [7:0]              PULSE_LAST   = 8'(PULSES_PER_ML - 1);
    localparam logic [AMOUNT_WIDTH-1:0] ONE_ML       = AMOUNT_WIDTH'(1);
    localparam logic [1:0]              FAULT_NONE   = 2'b00;
    localparam logic [1:0]              FAULT_TANK   = 2'b01;
    localparam logic [1:0]              FAULT_FLOW   = 2'b10;

    typedef enum logic [1:0] {IDLE, DISPENSING, DONE, FAULT} state_t;

    state_t                  state;
    logic [AMOUNT_WIDTH-1:0] target_lat;
    logic [7:0]              pulse_cnt;
    logic [TW-1:0]           timeout_cnt;
    logic                    flow_p0, flow_p1, flow_p2;
    logic                    flow_edge;

    function automatic logic [AMOUNT_WIDTH-1:0] sat_remaining(
        input logic [AMOUNT_WIDTH-1:0] tgt,
        input logic [AMOUNT_WIDTH-1:0] got
    );
        return (got > tgt) ? '0 : tgt - got;
    endfunction

    // Stage p0/p1: metastability synchroniser; p2: previous value for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            flow_p0 <= 1'b0;
            flow_p1 <= 1'b0;
            flow_p2 <= 1'b0;
        end else begin
            flow_p0 <= flow_pulse;
            flow_p1 <= flow_p0;
            flow_p2 <= flow_p1;
        end
    end

    assign flow_edge = flow_p1 & ~flow_p2;

    assign remaining_amount = (state == IDLE) ? '0 : sat_remaining(target_lat, dispensed_amount);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            valve_open       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            fault_code       <= FAULT_NONE;
            dispensed_amount <= '0;
            target_lat       <= '0;
            pulse_cnt        <= '0;
            timeout_cnt      <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && target_amount != '0) begin
                        if (tank_empty) begin
                            state      <= FAULT;
                            fault_code <= FAULT_TANK;
                        end else begin
                            state            <= DISPENSING;
                            valve_open       <= 1'b1;
                            busy             <= 1'b1;
                            target_lat       <= target_amount;
                            dispensed_amount <= '0;
                            pulse_cnt        <= '0;
                            timeout_cnt      <= '0;
                        end
                    end
                end
                DISPENSING: begin
                    if (cancel) begin
                        state      <= IDLE;
                        aborted    <= 1'b1;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                    end else if (tank_empty) begin
                        state      <= FAULT;
                        fault_code <= FAULT_TANK;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                    end else if (dispensed_amount == target_lat) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state      <= FAULT;
                        fault_code <= FAULT_FLOW;
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                    end else if (flow_edge) begin
                        timeout_cnt <= '0;
                        if (pulse_cnt == PULSE_LAST) begin
                            pulse_cnt        <= '0;
                            dispensed_amount <= dispensed_amount + ONE_ML;
                        end else begin
                            pulse_cnt <= pulse_cnt + 8'd1;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TIMEOUT_ONE;
                    end
                end
                DONE: state <= IDLE;
                FAULT: begin
                    // Only cancel leaves FAULT; start and flow are deliberately ignored
                    if (cancel) begin
                        state      <= IDLE;
                        fault_code <= FAULT_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: cycle model of the dispensing rules compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_dispense_controller;

    localparam int AW   = 14;
    localparam int PPM  = 2;
    localparam int TOUT = 100;

    logic          clock = 1'b0;
    logic          reset, start, cancel, flow_pulse, tank_empty;
    logic [AW-1:0] target_amount;
    logic          valve_open, busy, done, aborted;
    logic [1:0]    fault_code;
    logic [AW-1:0] dispensed_amount, remaining_amount;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    bit chk_en = 1'b0;

    dispense_controller #(
        .AMOUNT_WIDTH(AW), .PULSES_PER_ML(PPM), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .target_amount(target_amount),
        .cancel(cancel), .flow_pulse(flow_pulse), .tank_empty(tank_empty),
        .valve_open(valve_open), .busy(busy), .done(done), .aborted(aborted),
        .fault_code(fault_code), .dispensed_amount(dispensed_amount),
        .remaining_amount(remaining_amount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the dispensing rules
    typedef enum {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_t;
    mstate_t m_state = M_IDLE;
    int  m_target = 0, m_disp = 0, m_pulses = 0, m_quiet = 0, m_fault = 0;
    bit  m_valve = 0, m_busy = 0, m_done = 0, m_abort = 0;
    bit  h1 = 0, h2 = 0, h3 = 0;   // flow samples taken 1, 2, 3 edges ago

    always @(posedge clock) begin
        bit counted;
        counted = h2 && !h3;       // rise seen two edges ago counts on this edge
        m_done  = 0;
        m_abort = 0;
        if (reset) begin
            m_state = M_IDLE; m_target = 0; m_disp = 0; m_pulses = 0; m_quiet = 0;
            m_fault = 0; m_valve = 0; m_busy = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            h3 = h2; h2 = h1; h1 = flow_pulse;
            case (m_state)
                M_IDLE: if (start && target_amount != 0) begin
                    if (tank_empty) begin
                        m_state = M_FAULT; m_fault = 1;
                    end else begin
                        m_state = M_RUN; m_target = int'(target_amount);
                        m_disp = 0; m_pulses = 0; m_quiet = 0; m_valve = 1; m_busy = 1;
                    end
                end
                M_RUN: begin
                    if (cancel) begin
                        m_state = M_IDLE; m_abort = 1; m_valve = 0; m_busy = 0;
                    end else if (tank_empty) begin
                        m_state = M_FAULT; m_fault = 1; m_valve = 0; m_busy = 0;
                    end else if (m_disp == m_target) begin
                        m_state = M_DONE; m_done = 1; m_valve = 0; m_busy = 0;
                    end else if (m_quiet == TOUT - 1) begin
                        m_state = M_FAULT; m_fault = 2; m_valve = 0; m_busy = 0;
                    end else if (counted) begin
                        m_quiet = 0;
                        m_pulses++;
                        if (m_pulses == PPM) begin
                            m_pulses = 0;
                            m_disp++;
                        end
                    end else begin
                        m_quiet++;
                    end
                end
                M_DONE: m_state = M_IDLE;
                M_FAULT: if (cancel) begin
                    m_state = M_IDLE; m_fault = 0;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    always @(posedge clock) begin
        #2;
        if (chk_en) begin
            chk("valve_open", valve_open, m_valve);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("aborted", aborted, m_abort);
            chk("fault_code", fault_code, m_fault);
            chk("dispensed_amount", dispensed_amount, m_disp);
            chk("remaining_amount", remaining_amount,
                (m_state == M_IDLE) ? 0 : m_target - m_disp);
        end
        if (done === 1'b1) done_cnt++;
        if (aborted === 1'b1) abort_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_req(input int t);
        start = 1'b1; target_amount = AW'(t);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse();
        flow_pulse = 1'b1; cyc(2);
        flow_pulse = 1'b0; cyc(8);
    endtask

    task automatic cancel_req();
        cancel = 1'b1; cyc(1);
        cancel = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; flow_pulse = 1'b0;
        tank_empty = 1'b0; target_amount = '0;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("reset valve", valve_open, 0);
        chk("reset dispensed", dispensed_amount, 0);
        chk("reset fault", fault_code, 0);
        chk("reset remaining", remaining_amount, 0);

        // Normal dispense of 3 mL
        start_req(3);
        chk("normal valve opens", valve_open, 1);
        chk("normal remaining at start", remaining_amount, 3);
        repeat (6) pulse();
        chk("normal dispensed", dispensed_amount, 3);
        chk("normal remaining", remaining_amount, 0);
        chk("normal valve closed", valve_open, 0);
        chk("normal done pulses", done_cnt, 1);

        // Cancel after 2 mL
        start_req(5);
        repeat (4) pulse();
        chk("cancel pre dispensed", dispensed_amount, 2);
        cancel_req();
        chk("cancel aborted", aborted, 1);
        chk("cancel valve", valve_open, 0);
        repeat (2) pulse();
        chk("cancel dispensed held", dispensed_amount, 2);
        chk("cancel abort pulses", abort_cnt, 1);
        chk("cancel no done", done_cnt, 1);

        // No-flow timeout: fault 100 cycles after the edge counted 3 edges after the rise
        start_req(2);
        flow_pulse = 1'b1;
        cnt = 0;
        while (cnt < 300 && fault_code !== 2'b10) begin
            @(posedge clock); #2;
            cnt++;
            if (cnt == 2) flow_pulse = 1'b0;
        end
        flow_pulse = 1'b0;
        chk("timeout latency", cnt, 103);
        @(negedge clock);
        chk("timeout valve", valve_open, 0);
        start_req(2);
        cyc(2);
        chk("timeout start ignored", fault_code, 2);
        chk("timeout start no valve", valve_open, 0);
        cancel_req();
        chk("timeout cleared", fault_code, 0);

        // Tank empty at start
        tank_empty = 1'b1;
        start_req(4);
        chk("tank fault", fault_code, 1);
        cyc(3);
        chk("tank valve", valve_open, 0);
        cancel_req();
        chk("tank cleared", fault_code, 0);
        tank_empty = 1'b0;

        // Tank empty and cancel together while dispensing
        start_req(4);
        cyc(3);
        tank_empty = 1'b1; cancel = 1'b1;
        cyc(1);
        cancel = 1'b0;
        chk("tank+cancel aborted", aborted, 1);
        chk("tank+cancel fault", fault_code, 0);
        cyc(2);
        tank_empty = 1'b0;
        chk("tank+cancel abort pulses", abort_cnt, 2);

        // Ignored requests
        start_req(0);
        cyc(1);
        chk("zero target busy", busy, 0);
        start_req(3);
        cyc(2);
        start_req(9);
        cyc(1);
        chk("restart ignored remaining", remaining_amount, 3);
        repeat (6) pulse();
        chk("restart dispensed", dispensed_amount, 3);
        chk("restart done pulses", done_cnt, 2);
        repeat (3) pulse();
        chk("idle pulses ignored", dispensed_amount, 3);

        // Reset mid-dispense, then a fresh 1 mL dispense
        start_req(4);
        repeat (3) pulse();
        chk("pre-reset dispensed", dispensed_amount, 1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("mid reset valve", valve_open, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset dispensed", dispensed_amount, 0);
        chk("mid reset remaining", remaining_amount, 0);
        start_req(1);
        repeat (2) pulse();
        chk("post reset dispensed", dispensed_amount, 1);
        chk("post reset done pulses", done_cnt, 3);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispense_controller.md
Name:
dispense_controller

Overview:
- Sequences the dispensing phase once the keypad front-end has produced a confirmed `total_amount` in mL.
- Latches the target and opens the water valve.
- Counts flow-meter pulses into millilitres and closes the valve when the target is reached.
- Aborts on cancel, empty tank or a no-flow timeout; sits between the keypad/entry logic and the valve driver and display.

Parameters:
- AMOUNT_WIDTH, 14, width of the amount buses (holds 0..9999 mL).
- PULSES_PER_ML, 2, flow-meter pulses per mL; legal range 1..255.
- TIMEOUT_CYCLES, 50000000, clock cycles allowed without a counted flow pulse before a fault (1 s at 50 MHz).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle pulse from the entry logic requesting a dispense
- target_amount  input  AMOUNT_WIDTH  requested volume in mL, sampled only on an accepted start
- cancel  input  1  one-cycle pulse, already debounced and edge-detected
- flow_pulse  input  1  raw flow-meter output, asynchronous to clock
- tank_empty  input  1  level; 1 = reservoir empty, synchronous to clock
- valve_open  output  1  1 = valve energised
- busy  output  1  1 while in DISPENSING
- done  output  1  one-cycle pulse on successful completion
- aborted  output  1  one-cycle pulse when cancel ends a dispense
- fault_code  output  2  00 none, 01 tank empty, 10 no-flow timeout; held while in FAULT
- dispensed_amount  output  AMOUNT_WIDTH  mL delivered in the current or last dispense
- remaining_amount  output  AMOUNT_WIDTH  latched target minus dispensed_amount; 0 in IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; valve_open, busy, done and aborted 0; fault_code 00; dispensed_amount 0; latched target 0; pulse and timeout counters 0.
- Flow input path:
  - flow_pulse passes through a 2-flop synchroniser, then rising-edge detect.
  - A counted edge affects counters 3 cycles after the input rise.
  - Edges outside DISPENSING are discarded.
- States: IDLE, DISPENSING, DONE, FAULT.
- IDLE:
  - valve_open=0.
  - Start is accepted when start=1 and target_amount!=0 and tank_empty=0.
  - On acceptance: latch target; clear dispensed_amount, pulse counter and timeout counter; go to DISPENSING (valve_open=1 on the next cycle).
  - start with target_amount=0 is ignored.
  - start with tank_empty=1 goes to FAULT with fault_code=01.
- DISPENSING:
  - valve_open=1, busy=1.
  - Each counted edge increments the pulse counter. At PULSES_PER_ML-1 the counter wraps to 0 and dispensed_amount increments.
  - The timeout counter clears on each counted edge, otherwise increments.
- Per-cycle priority in DISPENSING, highest first:
  1. cancel: go to IDLE; aborted=1 for one cycle; valve closes next cycle; dispensed_amount is held.
  2. tank_empty=1: go to FAULT, fault_code=01.
  3. dispensed_amount == latched target: go to DONE.
  4. timeout counter == TIMEOUT_CYCLES-1: go to FAULT, fault_code=10.
- DONE:
  - Lasts exactly one cycle with done=1 and valve_open=0, then IDLE.
  - dispensed_amount is held until the next accepted start.
- FAULT:
  - valve_open=0; fault_code held.
  - start is ignored; flow edges are ignored.
  - cancel clears fault_code to 00 and returns to IDLE. aborted is not pulsed.
- Arithmetic: dispensed_amount never exceeds the latched target, because the increment that reaches the target triggers exit. remaining_amount is combinational from registers.
- start while not IDLE is ignored. target_amount changes after acceptance have no effect.
- reset asserted mid-dispense closes the valve on the next clock edge; partial pulse count is discarded.

Test Plan (PULSES_PER_ML=2, TIMEOUT_CYCLES=100):
- Normal dispense: reset, start with target_amount=3, then 6 flow pulses 10 cycles apart -> valve_open rises 1 cycle after start; dispensed_amount steps 1,2,3; done pulses once; valve_open=0; remaining_amount=0; dispensed_amount stays 3.
- Cancel mid-dispense: start with target=5, 4 pulses, cancel -> dispensed_amount=2, aborted pulses one cycle, valve closes next cycle, no done; further flow pulses do not change the count.
- No-flow timeout: start with target=2, 1 pulse, then silence -> fault_code=10 exactly 100 cycles after the last counted edge; valve_open=0; start ignored; cancel returns to IDLE with fault_code=00.
- Tank empty: start with tank_empty=1 and target=4 -> FAULT, fault_code=01, valve never opens. In a separate run, assert tank_empty during DISPENSING with cancel=1 on the same cycle -> aborted wins, fault_code stays 00.
- Ignored requests: start with target=0 -> stays IDLE. start during DISPENSING with a new target=9 -> latched target unchanged. 3 flow pulses in IDLE -> dispensed_amount unchanged.
- Synchronous reset mid-dispense: after 3 pulses toward target=4, assert reset for one cycle -> all outputs at reset values on the next edge. A following start with target=1 and 2 pulses gives done with dispensed_amount=1.
